// File: rtl/ece571f23_g5_aes_subbytes_pipe.sv
// Pipelined AES SubBytes / InvSubBytes engine: LANES independent byte lookups per beat,
// PIPE_STAGES elastic register stages with valid/ready on both sides, and a completed-beat counter.
module ece571f23_g5_aes_subbytes_pipe #(
  parameter int unsigned LANES       = 16,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned INV_EN      = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_inv,
  output logic [CNT_W-1:0]   beat_count
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Inverse table is derived from the forward one at elaboration, so the two can never disagree.
  function automatic logic [0:255][7:0] invert_table(input logic [0:255][7:0] t);
    logic [0:255][7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 256; i++) r[t[i]] = 8'(i);
    return r;
  endfunction

  localparam logic [0:255][7:0] INV_SBOX = invert_table(SBOX);

  logic [PIPE_STAGES-1:0] vld_q, vld_d;
  logic [PIPE_STAGES-1:0] inv_q, inv_d;
  logic [8*LANES-1:0]     dat_q [PIPE_STAGES];
  logic [8*LANES-1:0]     dat_d [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] ld;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [8*LANES-1:0]     lut_data;
  logic                   lut_inv;

  always_comb begin
    lut_inv  = (INV_EN != 0) && in_inv;
    lut_data = '0;
    for (int unsigned i = 0; i < LANES; i++)
      lut_data[8*i +: 8] = lut_inv ? INV_SBOX[in_data[8*i +: 8]] : SBOX[in_data[8*i +: 8]];
  end

  always_comb begin
    // Stage k can load unless it and every stage after it are full while the sink stalls.
    for (int unsigned k = 0; k < PIPE_STAGES; k++)
      ld[k] = out_ready || !(&(vld_q | PIPE_STAGES'((32'd1 << k) - 32'd1)));

    vld_d = vld_q;
    inv_d = inv_q;
    dat_d = dat_q;
    if (ld[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        dat_d[0] = lut_data;
        inv_d[0] = lut_inv;
      end
    end
    for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
      if (ld[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_d[k] = dat_q[k-1];
          inv_d[k] = inv_q[k-1];
        end
      end
    end

    cnt_d = cnt_q + CNT_W'(out_valid && out_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      inv_q <= '0;
      cnt_q <= '0;
      for (int unsigned k = 0; k < PIPE_STAGES; k++) dat_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      inv_q <= inv_d;
      cnt_q <= cnt_d;
      for (int unsigned k = 0; k < PIPE_STAGES; k++) dat_q[k] <= dat_d[k];
    end
  end

  assign in_ready   = ld[0];
  assign out_valid  = vld_q[PIPE_STAGES-1];
  assign out_data   = dat_q[PIPE_STAGES-1];
  assign out_inv    = inv_q[PIPE_STAGES-1];
  assign beat_count = cnt_q;

endmodule

// File: tb/tb_ece571f23_g5_aes_subbytes_pipe.sv
// Bench for the SubBytes pipe: a 16-lane/2-stage instance and a 4-lane/3-stage forward-only
// instance with a 4-bit counter, checked against S-boxes computed from GF(2^8) arithmetic.
module tb_ece571f23_g5_aes_subbytes_pipe;

  localparam int PIPE = 2;

  logic         clk;
  logic         reset;
  logic         in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
  logic [127:0] in_data, out_data;
  logic [15:0]  beat_count;
  logic         in_valid2, in_ready2, in_inv2, out_valid2, out_ready2, out_inv2;
  logic [31:0]  in_data2, out_data2;
  logic [3:0]   beat_count2;

  int checks;
  int failures;
  int hs_total;

  logic [7:0] fwd_tbl [256];
  logic [7:0] inv_tbl [256];

  ece571f23_g5_aes_subbytes_pipe #(.LANES(16), .PIPE_STAGES(2), .INV_EN(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_inv(out_inv),
    .beat_count(beat_count)
  );

  ece571f23_g5_aes_subbytes_pipe #(.LANES(4), .PIPE_STAGES(3), .INV_EN(0), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_inv(in_inv2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_inv(out_inv2),
    .beat_count(beat_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_tables();
    logic [7:0] a, r;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      r = 8'h00;
      if (a != 8'h00) begin
        r = 8'h01;
        for (int e = 0; e < 254; e++) r = gmul(r, a);
      end
      fwd_tbl[i] = r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    end
    for (int i = 0; i < 256; i++) inv_tbl[fwd_tbl[i]] = 8'(i);
  endtask

  function automatic logic [127:0] sub_beat(input logic [127:0] d, input logic inv, input int lanes);
    logic [127:0] r = '0;
    for (int i = 0; i < lanes; i++)
      r[8*i +: 8] = inv ? inv_tbl[d[8*i +: 8]] : fwd_tbl[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    hs_total = 0;
  endtask

  task automatic send_one(input logic [127:0] d, input logic inv,
                          output logic [127:0] got, output logic got_inv, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_inv = inv; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; in_data = rand128(); in_inv = ~inv;
    lat = 0; got = '0; got_inv = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c; got = out_data; got_inv = out_inv;
        break;
      end
    end
    if (lat != 0) hs_total++;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    do_reset(2);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_inv !== 1'b0 || beat_count !== 16'd0)
      begin failures++; $display("FAIL reset_outputs: got v=%b d=%h i=%b cnt=%0d required 0/0/0/0", out_valid, out_data, out_inv, beat_count); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++;
    if (out_valid2 !== 1'b0 || beat_count2 !== 4'd0)
      begin failures++; $display("FAIL reset_dut2: got v=%b cnt=%0d required 0/0", out_valid2, beat_count2); end
  endtask

  task automatic test_fips_vectors();
    logic [7:0] fe [16] = '{8'h63, 8'h7C, 8'h77, 8'h7B, 8'hF2, 8'h6B, 8'h6F, 8'hC5,
                           8'h30, 8'h01, 8'h67, 8'h2B, 8'hFE, 8'hD7, 8'hAB, 8'h76};
    logic [127:0] d, exp, got, d2, exp2;
    logic gi;
    int lat;
    for (int i = 0; i < 16; i++) begin d[8*i +: 8] = 8'(i); exp[8*i +: 8] = fe[i]; end
    send_one(d, 1'b0, got, gi, lat);
    checks++;
    if (lat != PIPE) begin failures++; $display("FAIL fips_latency: got %0d required %0d", lat, PIPE); end
    checks++;
    if (got !== exp || gi !== 1'b0) begin failures++; $display("FAIL fips_seq: got %h/%b required %h/0", got, gi, exp); end
    @(negedge clk);
    checks++;
    if (beat_count !== 16'd1) begin failures++; $display("FAIL fips_count: got %0d required 1", beat_count); end

    d2   = {96'h0, 8'hE9, 8'h9A, 8'hA0, 8'h19};
    exp2 = {{12{8'h63}}, 8'h1E, 8'hB8, 8'hE0, 8'hD4};
    send_one(d2, 1'b0, got, gi, lat);
    checks++;
    if (got !== exp2) begin failures++; $display("FAIL fwd_round_vec: got %h required %h", got, exp2); end
    send_one(got, 1'b1, got, gi, lat);
    checks++;
    if (got !== d2 || gi !== 1'b1) begin failures++; $display("FAIL inv_round_vec: got %h/%b required %h/1", got, gi, d2); end
  endtask

  task automatic test_inverse_spots();
    logic [127:0] d, exp, got;
    logic gi;
    int lat;
    d   = {96'h0, 8'h52, 8'hED, 8'h63, 8'h16};
    exp = {{12{8'h52}}, 8'h48, 8'h53, 8'h00, 8'hFF};
    send_one(d, 1'b1, got, gi, lat);
    checks++;
    if (got !== exp || gi !== 1'b1) begin failures++; $display("FAIL inv_spots: got %h/%b required %h/1", got, gi, exp); end
  endtask

  task automatic test_round_trip();
    logic [127:0] d, fwd, back;
    logic gi;
    int lat;
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16*b + i);
      send_one(d, 1'b0, fwd, gi, lat);
      checks++;
      if (fwd !== sub_beat(d, 1'b0, 16))
        begin failures++; $display("FAIL round_fwd_%0d: got %h required %h", b, fwd, sub_beat(d, 1'b0, 16)); end
      send_one(fwd, 1'b1, back, gi, lat);
      checks++;
      if (back !== d || gi !== 1'b1)
        begin failures++; $display("FAIL round_inv_%0d: got %h/%b required %h/1", b, back, gi, d); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] qd[$];
    logic         qi[$];
    logic [127:0] cur_d, prev_d;
    logic         cur_i, prev_i, prev_stall, exp_rdy;
    int sent, recv;
    do_reset(1);
    sent = 0; recv = 0; prev_stall = 1'b0; prev_d = '0; prev_i = 1'b0;
    cur_d = rand128(); cur_i = 1'($urandom_range(0, 1));
    for (int c = 0; c < 200 && recv < 10; c++) begin
      @(negedge clk);
      out_ready = (c % 3 == 0);
      in_valid = (sent < 10); in_data = cur_d; in_inv = cur_i;
      #1;
      checks++;
      if (beat_count !== 16'(hs_total)) begin failures++; $display("FAIL b2b_count: got %0d required %0d", beat_count, hs_total); end
      if (prev_stall) begin
        checks++;
        if (out_data !== prev_d || out_inv !== prev_i)
          begin failures++; $display("FAIL b2b_stall_hold: got %h/%b required %h/%b", out_data, out_inv, prev_d, prev_i); end
      end
      exp_rdy = !(qd.size() == PIPE && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin failures++; $display("FAIL b2b_in_ready: got %b required %b", in_ready, exp_rdy); end
      if (out_valid && out_ready) begin
        checks++;
        if (qd.size() == 0) begin failures++; $display("FAIL b2b_spurious: got beat %h required none", out_data); end
        else begin
          if (out_data !== qd[0] || out_inv !== qi[0])
            begin failures++; $display("FAIL b2b_data: got %h/%b required %h/%b", out_data, out_inv, qd[0], qi[0]); end
          void'(qd.pop_front()); void'(qi.pop_front());
        end
        recv++; hs_total++;
      end
      if (in_valid && in_ready) begin
        qd.push_back(sub_beat(cur_d, cur_i, 16)); qi.push_back(cur_i);
        sent++;
        cur_d = rand128(); cur_i = 1'($urandom_range(0, 1));
      end
      prev_stall = out_valid && !out_ready; prev_d = out_data; prev_i = out_inv;
    end
    checks++;
    if (recv != 10) begin failures++; $display("FAIL b2b_received: got %0d required 10", recv); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (beat_count !== 16'd10) begin failures++; $display("FAIL b2b_final_count: got %0d required 10", beat_count); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] d, got;
    logic gi, filled, stale;
    int lat;
    filled = 1'b0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data = rand128(); in_inv = 1'b0;
      #1;
      if (!in_ready) begin filled = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!filled || out_valid !== 1'b1) begin failures++; $display("FAIL mid_fill: got filled=%b v=%b required 1/1", filled, out_valid); end
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    hs_total = 0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || beat_count !== 16'd0 || out_data !== '0 || out_inv !== 1'b0)
      begin failures++; $display("FAIL mid_reset_out: got v=%b cnt=%0d d=%h required 0/0/0", out_valid, beat_count, out_data); end
    out_ready = 1'b1; stale = 1'b0;
    repeat (4) begin @(negedge clk); if (out_valid !== 1'b0) stale = 1'b1; end
    checks++;
    if (stale) begin failures++; $display("FAIL mid_stale_beat: got stale=1 required 0"); end
    d = rand128();
    send_one(d, 1'b0, got, gi, lat);
    checks++;
    if (lat != PIPE || got !== sub_beat(d, 1'b0, 16))
      begin failures++; $display("FAIL mid_new_beat: got %h lat %0d required %h lat %0d", got, lat, sub_beat(d, 1'b0, 16), PIPE); end
  endtask

  task automatic test_wrap_fwd_only();
    logic [31:0]  q2[$];
    logic [31:0]  cur;
    logic [127:0] m;
    int sent, recv, first, hs2;
    do_reset(1);
    sent = 0; recv = 0; first = -1; hs2 = 0;
    cur = $urandom(); cur[7:0] = 8'h53;
    for (int c = 0; c < 100 && recv < 17; c++) begin
      @(negedge clk);
      out_ready2 = 1'b1; in_valid2 = (sent < 17); in_data2 = cur; in_inv2 = 1'b1;
      #1;
      checks++;
      if (beat_count2 !== 4'(hs2)) begin failures++; $display("FAIL wrap_count: got %0d required %0d", beat_count2, hs2 % 16); end
      if (out_valid2 && first < 0) first = c;
      if (out_valid2 && out_ready2) begin
        checks++;
        if (q2.size() == 0) begin failures++; $display("FAIL fwd_only_spurious: got %h required none", out_data2); end
        else begin
          if (out_data2 !== q2[0] || out_inv2 !== 1'b0)
            begin failures++; $display("FAIL fwd_only_data: got %h/%b required %h/0", out_data2, out_inv2, q2[0]); end
          void'(q2.pop_front());
        end
        if (recv == 0) begin
          checks++;
          if (out_data2[7:0] !== 8'hED) begin failures++; $display("FAIL fwd_only_53: got %h required ed", out_data2[7:0]); end
        end
        recv++; hs2++;
      end
      if (in_valid2 && in_ready2) begin
        m = sub_beat({96'h0, cur}, 1'b0, 4);
        q2.push_back(m[31:0]);
        sent++;
        cur = $urandom();
      end
    end
    checks++;
    if (recv != 17 || first != 3) begin failures++; $display("FAIL wrap_stream: got recv=%0d first=%0d required 17/3", recv, first); end
    @(negedge clk);
    in_valid2 = 1'b0;
    checks++;
    if (beat_count2 !== 4'd1) begin failures++; $display("FAIL wrap_final: got %0d required 1", beat_count2); end
  endtask

  initial begin
    checks = 0; failures = 0; hs_total = 0;
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0; in_inv2 = 1'b0; out_ready2 = 1'b1;
    build_tables();
    test_reset();
    test_fips_vectors();
    test_inverse_spots();
    test_round_trip();
    test_back_to_back();
    test_reset_mid();
    test_wrap_fwd_only();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
